data_skew_buffer: RTL and testbench
===================================

# data_skew_buffer

Parametrised staircase skew/deskew buffer for the systolic-array datapath. Lane i of a DATA_NUM-wide vector is delayed by a mode-dependent multiple of STEP cycles. In skew mode it feeds row/column operands into the array; in deskew mode it realigns array outputs. Control sideband is delayed by the full staircase depth. Adds stall, flush, a runtime mode switch guarded by an in-flight counter, and synchronous reset.

## Interface
- DATA_WIDTH, 16, bits per lane
- DATA_NUM, 16, lane count (≥1)
- STEP, 1, cycles of delay per lane step (≥1)
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- en_i  input  1  advance enable; 0 = all state holds
- flush_i  input  1  clear control chains and in-flight count
- mode_i  input  1  requested mode: 0 = skew, 1 = deskew
- mode_load_i  input  1  request to load mode_i
- data_in  input  DATA_WIDTH×DATA_NUM  unpacked lane array
- input_valid_i, calc_done_i, is_init_data_i  input  1 each  sideband
- data_out  output  DATA_WIDTH×DATA_NUM  delayed lanes
- input_valid_o, calc_done_o, is_init_data_o  output  1 each  sideband delayed by L
- mode_o  output  1  active mode
- busy_o  output  1  in-flight count ≠ 0
- mode_err_o  output  1  sticky: mode load rejected
- lane_valid_o  output  DATA_NUM  per-lane valid (macro only)

## Operation
- L = (DATA_NUM−1)·STEP. Lane delay D_i = i·STEP in skew mode and (DATA_NUM−1−i)·STEP in deskew mode.
- Each lane is a shift register of depth L with a tap mux selected by mode_o. D_i = 0 is a combinational passthrough.
- Sideband: 3-bit shift chain of depth L. If L = 0, passthrough.
- In-flight counter, width clog2(L+1):
  - +1 on input_valid_i&en_i.
  - −1 on input_valid_o&en_i.
  - Both in the same cycle: unchanged.
  - Never wraps.
- Mode load accepted only when mode_load_i=1, count=0 and input_valid_i=0. Then mode_o ← mode_i next cycle.
- Any other mode_load_i: ignored, mode_err_o ← 1, which stays set until reset.
- flush_i (priority over en_i):
  - Sideband chains ← 0 and counter ← 0.
  - Data registers untouched.
  - Mode load in the same cycle is evaluated as if count=0.
- Priority, highest first: rst_n, flush_i, en_i.

## Timing
- Reset values:
  - All data registers 0.
  - Sideband chains 0, so input_valid_o/calc_done_o/is_init_data_o = 0.
  - mode_o = 0, busy_o = 0, mode_err_o = 0, lane_valid_o = 0.
- Latency: sideband L enabled cycles. Lane i: D_i enabled cycles. Cycles with en_i=0 do not count.
- Passthrough lanes and L = 0 outputs follow inputs in the same cycle regardless of en_i.
- busy_o is registered. It reflects the count after the current edge.
- Switching the mode tap does not move data already in the registers. Hence the empty-pipe rule for mode loads.
- Reset asserted mid-stream discards all in-flight tokens. Output is clean on the first cycle after release.

## Configuration
- DATA_SKEW_LANE_VALID_EN defined:
  - Each lane carries a 1-bit valid alongside its data. It is fed by input_valid_i and delayed by D_i, and drives lane_valid_o[i].
  - data_out[i] is forced to 0 when lane_valid_o[i]=0.
  - flush_i clears the lane valid bits.
- Not defined:
  - lane_valid_o is tied to 0.
  - data_out is raw register contents, with no zero-fill.

## Test plan
- DATA_NUM=4, STEP=1, skew: apply 4 vectors, data_in[i]=16·t+i at t=0..3 with valid=1 → data_out[i] shows 16·t+i at cycle t+i; input_valid_o high at cycles 3..6; busy_o falls after cycle 6.
- Same vectors in deskew mode, STEP=2 → lane 3 appears at cycle t, lane 0 at cycle t+6; input_valid_o at cycle t+6.
- Stall: hold en_i=0 for 5 cycles mid-stream → every output is frozen; all latencies stretch by exactly 5; counter unchanged.
- Mode load while busy_o=1 → mode_o unchanged, mode_err_o=1 until rst_n=0. Load after drain (count=0, valid_i=0) → mode_o flips next cycle, mode_err_o unaffected.
- flush_i with 3 tokens in flight and en_i=0 → input_valid_o=0 and busy_o=0 next cycle; an immediately following mode load is accepted.
- DATA_SKEW_LANE_VALID_EN: single valid vector then idle, with nonzero stale data in the registers → data_out[i] nonzero only in the cycle lane_valid_o[i]=1, zero otherwise.

Source files
------------

// File: rtl/data_skew_buffer.sv
// rtl/data_skew_buffer.sv - staircase skew/deskew buffer for the systolic-array datapath
//
// Lane i is delayed by i*STEP enabled cycles in skew mode (mode_o=0) or by
// (DATA_NUM-1-i)*STEP in deskew mode (mode_o=1). The sideband triple is
// delayed by the full staircase depth L=(DATA_NUM-1)*STEP. A zero delay is a
// combinational passthrough.
//
// Optional feature macro: DATA_SKEW_LANE_VALID_EN (per-lane valid with
// zero-fill of data_out); undefined by default.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   en_i                advance enable (0 = all state holds)
//   flush_i             clear sideband chains, lane valids and in-flight count
//   mode_i, mode_load_i requested mode and load strobe
//   data_in             DATA_NUM lanes of DATA_WIDTH bits
//   input_valid_i, calc_done_i, is_init_data_i   sideband in
//   data_out            delayed lanes
//   input_valid_o, calc_done_o, is_init_data_o   sideband delayed by L
//   mode_o              active mode
//   busy_o              in-flight count is nonzero (registered)
//   mode_err_o          sticky: a mode load was rejected
//   lane_valid_o        per-lane valid (zero unless the macro is defined)
module data_skew_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_NUM   = 16,
  parameter int STEP       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  flush_i,
  input  logic                  mode_i,
  input  logic                  mode_load_i,
  input  logic [DATA_WIDTH-1:0] data_in [DATA_NUM],
  input  logic                  input_valid_i,
  input  logic                  calc_done_i,
  input  logic                  is_init_data_i,
  output logic [DATA_WIDTH-1:0] data_out [DATA_NUM],
  output logic                  input_valid_o,
  output logic                  calc_done_o,
  output logic                  is_init_data_o,
  output logic                  mode_o,
  output logic                  busy_o,
  output logic                  mode_err_o,
  output logic [DATA_NUM-1:0]   lane_valid_o
);

  localparam int L     = (DATA_NUM - 1) * STEP;
  localparam int DEPTH = (L > 0) ? L : 1;
  localparam int CW    = (L > 0) ? $clog2(L + 1) : 1;

  // Sideband chain: {is_init_data, calc_done, input_valid}
  logic [2:0] sb_in;
  logic [2:0] sb_out;
  assign sb_in = {is_init_data_i, calc_done_i, input_valid_i};

  generate
    if (L == 0) begin : g_sb_pass
      assign sb_out = sb_in;
    end else begin : g_sb_chain
      logic [2:0] sb [DEPTH];
      always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
          for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
        end else if (en_i) begin
          sb[0] <= sb_in;
          for (int k = 1; k < DEPTH; k++) sb[k] <= sb[k-1];
        end
      end
      assign sb_out = sb[DEPTH-1];
    end
  endgenerate

  assign input_valid_o  = sb_out[0];
  assign calc_done_o    = sb_out[1];
  assign is_init_data_o = sb_out[2];

  // In-flight token counter; saturates rather than wrapping
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          inc;
  logic          dec;

  always_comb begin
    inc     = input_valid_i & en_i;
    dec     = input_valid_o & en_i;
    cnt_nxt = cnt;
    if (inc && !dec && cnt != '1)
      cnt_nxt = cnt + 1'b1;
    else if (dec && !inc && cnt != '0)
      cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      cnt    <= '0;
      busy_o <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      busy_o <= (cnt_nxt != '0);
    end
  end

  // The tap switch does not move stored data, so a mode change is only safe
  // with an empty pipe. A flush in the same cycle empties it.
  logic load_ok;
  assign load_ok = mode_load_i && !input_valid_i && (flush_i || cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_o     <= 1'b0;
      mode_err_o <= 1'b0;
    end else if (mode_load_i) begin
      if (load_ok) mode_o     <= mode_i;
      else         mode_err_o <= 1'b1;
    end
  end

  // Lanes: each keeps only as many stages as its deepest selectable tap
  generate
    for (genvar i = 0; i < DATA_NUM; i++) begin : g_lane
      localparam int DS = i * STEP;
      localparam int DD = (DATA_NUM - 1 - i) * STEP;
      localparam int LD = (DS > DD) ? DS : DD;

      logic [DATA_WIDTH-1:0] tap_s;
      logic [DATA_WIDTH-1:0] tap_d;
      logic [DATA_WIDTH-1:0] raw;
`ifdef DATA_SKEW_LANE_VALID_EN
      logic v_s;
      logic v_d;
      logic lv;
`endif

      if (LD == 0) begin : g_pass
        assign tap_s = data_in[i];
        assign tap_d = data_in[i];
`ifdef DATA_SKEW_LANE_VALID_EN
        assign v_s = input_valid_i;
        assign v_d = input_valid_i;
`endif
      end else begin : g_sr
        logic [DATA_WIDTH-1:0] sr [LD];

        // Data stages are not cleared by flush
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            for (int k = 0; k < LD; k++) sr[k] <= '0;
          end else if (en_i && !flush_i) begin
            sr[0] <= data_in[i];
            for (int k = 1; k < LD; k++) sr[k] <= sr[k-1];
          end
        end

`ifdef DATA_SKEW_LANE_VALID_EN
        logic [LD-1:0] vr;
        always_ff @(posedge clk) begin
          if (!rst_n || flush_i) vr <= '0;
          else if (en_i)         vr <= {vr, input_valid_i};
        end
`endif

        if (DS == 0) begin : g_s0
          assign tap_s = data_in[i];
`ifdef DATA_SKEW_LANE_VALID_EN
          assign v_s = input_valid_i;
`endif
        end else begin : g_sn
          assign tap_s = sr[DS-1];
`ifdef DATA_SKEW_LANE_VALID_EN
          assign v_s = vr[DS-1];
`endif
        end

        if (DD == 0) begin : g_d0
          assign tap_d = data_in[i];
`ifdef DATA_SKEW_LANE_VALID_EN
          assign v_d = input_valid_i;
`endif
        end else begin : g_dn
          assign tap_d = sr[DD-1];
`ifdef DATA_SKEW_LANE_VALID_EN
          assign v_d = vr[DD-1];
`endif
        end
      end

      assign raw = mode_o ? tap_d : tap_s;

`ifdef DATA_SKEW_LANE_VALID_EN
      assign lv              = mode_o ? v_d : v_s;
      assign lane_valid_o[i] = lv;
      assign data_out[i]     = lv ? raw : '0;
`else
      assign lane_valid_o[i] = 1'b0;
      assign data_out[i]     = raw;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_data_skew_buffer.sv
// tb/tb_data_skew_buffer.sv - self-checking bench for data_skew_buffer
module tb_data_skew_buffer;

  localparam int W    = 16;
  localparam int N    = 4;
  localparam int STEP = 2;
  localparam int L    = (N - 1) * STEP;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en_i;
  logic         flush_i;
  logic         mode_i;
  logic         mode_load_i;
  logic [W-1:0] data_in [N];
  logic         input_valid_i;
  logic         calc_done_i;
  logic         is_init_data_i;
  logic [W-1:0] data_out [N];
  logic         input_valid_o;
  logic         calc_done_o;
  logic         is_init_data_o;
  logic         mode_o;
  logic         busy_o;
  logic         mode_err_o;
  logic [N-1:0] lane_valid_o;

  always #5 clk = ~clk;

  data_skew_buffer #(.DATA_WIDTH(W), .DATA_NUM(N), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .flush_i(flush_i),
    .mode_i(mode_i), .mode_load_i(mode_load_i), .data_in(data_in),
    .input_valid_i(input_valid_i), .calc_done_i(calc_done_i),
    .is_init_data_i(is_init_data_i), .data_out(data_out),
    .input_valid_o(input_valid_o), .calc_done_o(calc_done_o),
    .is_init_data_o(is_init_data_o), .mode_o(mode_o), .busy_o(busy_o),
    .mode_err_o(mode_err_o), .lane_valid_o(lane_valid_o)
  );

  // Reference: history of enabled-cycle input records, newest first.
  // Whatever a lane of delay D shows is the record from D enabled edges ago.
  typedef struct packed {
    logic [N*W-1:0] d;
    logic           v;
    logic           c;
    logic           ii;
  } rec_t;

  rec_t hist[$];
  logic m_mode;
  logic m_err;
  int   checks   = 0;
  int   failures = 0;

  function automatic logic m_busy();
    for (int k = 0; k < L; k++) if (hist[k].v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic reset_model();
    hist.delete();
    for (int k = 0; k < L; k++) hist.push_back('0);
    m_mode = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < N; i++) begin
      int           dly;
      logic [W-1:0] ed;
      logic         ev;
      dly = m_mode ? (N - 1 - i) * STEP : i * STEP;
      if (dly == 0) begin
        ed = data_in[i];
        ev = input_valid_i;
      end else begin
        ed = hist[dly-1].d[i*W +: W];
        ev = hist[dly-1].v;
      end
`ifdef DATA_SKEW_LANE_VALID_EN
      if (!ev) ed = '0;
      check($sformatf("lane_valid_o[%0d]", i), W'(lane_valid_o[i]), W'(ev));
`else
      check($sformatf("lane_valid_o[%0d]", i), W'(lane_valid_o[i]), '0);
`endif
      check($sformatf("data_out[%0d]", i), data_out[i], ed);
    end
    check("input_valid_o", W'(input_valid_o), W'(hist[L-1].v));
    check("calc_done_o", W'(calc_done_o), W'(hist[L-1].c));
    check("is_init_data_o", W'(is_init_data_o), W'(hist[L-1].ii));
    check("mode_o", W'(mode_o), W'(m_mode));
    check("busy_o", W'(busy_o), W'(m_busy()));
    check("mode_err_o", W'(mode_err_o), W'(m_err));
  endtask

  // Check the current cycle, then advance one clock and the model with it.
  task automatic tick();
    logic zero;
    rec_t r;
    #1;
    check_outputs();
    zero = !m_busy();
    for (int i = 0; i < N; i++) r.d[i*W +: W] = data_in[i];
    r.v  = input_valid_i;
    r.c  = calc_done_i;
    r.ii = is_init_data_i;
    @(posedge clk);
    if (!rst_n) begin
      reset_model();
    end else begin
      if (mode_load_i) begin
        if (!input_valid_i && (flush_i || zero)) m_mode = mode_i;
        else m_err = 1'b1;
      end
      if (flush_i) begin
        for (int k = 0; k < hist.size(); k++) begin
          hist[k].v  = 1'b0;
          hist[k].c  = 1'b0;
          hist[k].ii = 1'b0;
        end
      end else if (en_i) begin
        hist.push_front(r);
        void'(hist.pop_back());
      end
    end
    #1;
  endtask

  task automatic vec(input int t, input logic v, input logic c, input logic ii);
    for (int i = 0; i < N; i++) data_in[i] = W'(16 * t + i);
    en_i           = 1'b1;
    input_valid_i  = v;
    calc_done_i    = c;
    is_init_data_i = ii;
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) data_in[i] = W'($urandom_range(1, 16'hffff));
    en_i           = 1'b1;
    input_valid_i  = 1'b0;
    calc_done_i    = 1'b0;
    is_init_data_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en_i = 1'b0; flush_i = 1'b0; mode_i = 1'b0; mode_load_i = 1'b0;
    input_valid_i = 1'b0; calc_done_i = 1'b0; is_init_data_i = 1'b0;
    for (int i = 0; i < N; i++) data_in[i] = '0;
    @(posedge clk);
    reset_model();
    #1;
    tick();
    rst_n = 1'b1;

    // Skew mode: four vectors, then drain with stale nonzero data on the inputs
    for (int t = 0; t < 4; t++) begin
      vec(t, 1'b1, t == 3, t == 0);
      tick();
    end
    idle();
    repeat (9) tick();

    // Empty pipe: load deskew
    mode_i = 1'b1; mode_load_i = 1'b1;
    tick();
    mode_load_i = 1'b0;
    tick();

    // Deskew with a 5-cycle stall mid-stream
    for (int t = 0; t < 4; t++) begin
      vec(t, 1'b1, t == 3, t == 0);
      tick();
      if (t == 1) begin
        idle();
        en_i = 1'b0;
        input_valid_i = 1'b1;
        repeat (5) tick();
      end
    end
    idle();
    repeat (10) tick();

    // Mode load while busy is rejected and sets the sticky error
    vec(7, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    mode_i = 1'b0; mode_load_i = 1'b1;
    tick();
    mode_load_i = 1'b0;
    repeat (8) tick();
    // Drained: load is accepted, error stays set
    mode_load_i = 1'b1;
    tick();
    mode_load_i = 1'b0;
    tick();

    // Flush with three tokens in flight, then an immediate mode load
    for (int t = 0; t < 3; t++) begin
      vec(t + 3, 1'b1, 1'b1, 1'b1);
      tick();
    end
    idle();
    en_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; mode_i = 1'b1; mode_load_i = 1'b1;
    tick();
    mode_load_i = 1'b0;
    repeat (4) tick();

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < N; i++) data_in[i] = W'($urandom);
      en_i           = ($urandom_range(0, 4) != 0);
      input_valid_i  = $urandom_range(0, 1);
      calc_done_i    = $urandom_range(0, 1);
      is_init_data_i = $urandom_range(0, 1);
      flush_i        = !en_i && ($urandom_range(0, 5) == 0);
      mode_load_i    = ($urandom_range(0, 14) == 0);
      mode_i         = $urandom_range(0, 1);
      tick();
    end
    flush_i = 1'b0; mode_load_i = 1'b0;

    // Reset mid-stream discards in-flight tokens
    for (int t = 0; t < 3; t++) begin
      vec(t + 9, 1'b1, 1'b1, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
